// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the port-B RAM arbiter and its read-return pipeline.
package ram_arb_pkg;

    localparam int unsigned STARVE_W = 4;
    localparam logic [STARVE_W-1:0] STARVE_MAX = '1;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DMA  = 2'd1,
        OWN_PRAM = 2'd2
    } owner_e;

endpackage

// File: rtl/ram_arb_rd_pipe.sv
// Owner-tag delay line matching the RAM read latency; the exiting tag steers read data.
module ram_arb_rd_pipe
    import ram_arb_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  owner_e tag_i,
    output owner_e tag_o
);

    owner_e tag_q [RD_LAT];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(RD_LAT); i++) begin
                tag_q[i] <= OWN_NONE;
            end
        end else begin
            tag_q[0] <= tag_i;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tag_o = tag_q[RD_LAT-1];

endmodule

// File: rtl/ram_port_b_arbiter.sv
// Port-B request/grant arbiter between DMA and the parallel-process requester:
// fixed DMA priority, bounded by a starvation counter and an exclusive DMA lock.
module ram_port_b_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                physical_clock,
    input  logic                reset,
    input  logic                dma_req,
    input  logic                dma_we,
    input  logic                dma_lock,
    input  logic [ADDR_W-1:0]   dma_addr,
    input  logic [DATA_W-1:0]   dma_wdata,
    output logic                dma_gnt,
    output logic                dma_rvalid,
    output logic [DATA_W-1:0]   dma_rdata,
    input  logic                pram_req,
    input  logic                pram_we,
    input  logic [ADDR_W-1:0]   pram_addr,
    input  logic [DATA_W-1:0]   pram_wdata,
    output logic                pram_gnt,
    output logic                pram_rvalid,
    output logic [DATA_W-1:0]   pram_rdata,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata,
    output logic [STARVE_W-1:0] starve_cnt
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_q;
    logic [STARVE_W-1:0] starve_d;
    owner_e              win;
    owner_e              tag_push;
    owner_e              tag_exit;

    // Winner selection; lock excludes pram even when DMA is idle.
    always_comb begin
        win = OWN_NONE;
        if (reset) begin
            win = OWN_NONE;
        end else if (dma_lock) begin
            if (dma_req) win = OWN_DMA;
        end else if (pram_req && (starve_q >= LIMIT)) begin
            win = OWN_PRAM;
        end else if (dma_req) begin
            win = OWN_DMA;
        end else if (pram_req) begin
            win = OWN_PRAM;
        end
    end

    assign dma_gnt  = (win == OWN_DMA);
    assign pram_gnt = (win == OWN_PRAM);

    // Port-B command mux and the owner tag for reads.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        tag_push  = OWN_NONE;
        case (win)
            OWN_DMA: begin
                ram_we    = dma_we;
                ram_addr  = dma_addr;
                ram_wdata = dma_wdata;
                if (!dma_we) tag_push = OWN_DMA;
            end
            OWN_PRAM: begin
                ram_we    = pram_we;
                ram_addr  = pram_addr;
                ram_wdata = pram_wdata;
                if (!pram_we) tag_push = OWN_PRAM;
            end
            default: ;
        endcase
    end

    always_comb begin
        starve_d = '0;
        if (pram_req && !pram_gnt) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge physical_clock) begin
        if (reset) starve_q <= '0;
        else       starve_q <= starve_d;
    end

    assign starve_cnt = starve_q;

    ram_arb_rd_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk_i (physical_clock),
        .rst_i (reset),
        .tag_i (tag_push),
        .tag_o (tag_exit)
    );

    // Read return; masked during reset so a flushed read never surfaces.
    assign dma_rvalid  = !reset && (tag_exit == OWN_DMA);
    assign pram_rvalid = !reset && (tag_exit == OWN_PRAM);
    assign dma_rdata   = dma_rvalid  ? ram_rdata : '0;
    assign pram_rdata  = pram_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_port_b_arbiter.sv
// Bench for ram_port_b_arbiter: two instances (read latency 1 and 3) share stimulus,
// each with its own RAM, checked against a cycle-level reference model.
module tb_ram_port_b_arbiter;

    localparam int unsigned AW  = 16;
    localparam int unsigned DW  = 32;
    localparam int unsigned LIM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          dma_req, dma_we, dma_lock, pram_req, pram_we;
    logic [AW-1:0] dma_addr, pram_addr;
    logic [DW-1:0] dma_wdata, pram_wdata;

    logic          dma_gnt_w [2];
    logic          pram_gnt_w [2];
    logic          dma_rv_w [2];
    logic          pram_rv_w [2];
    logic          ram_we_w [2];
    logic [DW-1:0] dma_rd_w [2];
    logic [DW-1:0] pram_rd_w [2];
    logic [DW-1:0] ram_wd_w [2];
    logic [DW-1:0] ram_rd_w [2];
    logic [AW-1:0] ram_ad_w [2];
    logic [3:0]    starve_w [2];

    always #5 clk = ~clk;

    ram_port_b_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .STARVE_LIMIT(LIM)) u_lat1 (
        .physical_clock(clk), .reset(rst),
        .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt_w[0]), .dma_rvalid(dma_rv_w[0]),
        .dma_rdata(dma_rd_w[0]),
        .pram_req(pram_req), .pram_we(pram_we), .pram_addr(pram_addr), .pram_wdata(pram_wdata),
        .pram_gnt(pram_gnt_w[0]), .pram_rvalid(pram_rv_w[0]), .pram_rdata(pram_rd_w[0]),
        .ram_we(ram_we_w[0]), .ram_addr(ram_ad_w[0]), .ram_wdata(ram_wd_w[0]),
        .ram_rdata(ram_rd_w[0]), .starve_cnt(starve_w[0])
    );

    ram_port_b_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .STARVE_LIMIT(LIM)) u_lat3 (
        .physical_clock(clk), .reset(rst),
        .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt_w[1]), .dma_rvalid(dma_rv_w[1]),
        .dma_rdata(dma_rd_w[1]),
        .pram_req(pram_req), .pram_we(pram_we), .pram_addr(pram_addr), .pram_wdata(pram_wdata),
        .pram_gnt(pram_gnt_w[1]), .pram_rvalid(pram_rv_w[1]), .pram_rdata(pram_rd_w[1]),
        .ram_we(ram_we_w[1]), .ram_addr(ram_ad_w[1]), .ram_wdata(ram_wd_w[1]),
        .ram_rdata(ram_rd_w[1]), .starve_cnt(starve_w[1])
    );

    function automatic logic [31:0] pat(int i);
        case (i)
            1:       return 32'h1111_1111;
            2:       return 32'h2222_2222;
            3:       return 32'h3333_3333;
            16:      return 32'hDEAD_BEEF;
            default: return 32'h9E37_79B9 * 32'(i) + 32'd7;
        endcase
    endfunction

    function automatic int lat(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // RAM environment: 256 words per instance, latency-matched read data pipe.
    logic [DW-1:0] mem [2][256];
    logic [DW-1:0] rpipe [2][3];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int i = 0; i < 256; i++) mem[k][i] <= pat(i);
                for (int s = 0; s < 3; s++) rpipe[k][s] <= '0;
            end else begin
                if (ram_we_w[k]) mem[k][ram_ad_w[k][7:0]] <= ram_wd_w[k];
                rpipe[k][0] <= mem[k][ram_ad_w[k][7:0]];
                rpipe[k][1] <= rpipe[k][0];
                rpipe[k][2] <= rpipe[k][1];
            end
        end
    end

    assign ram_rd_w[0] = rpipe[0][0];
    assign ram_rd_w[1] = rpipe[1][2];

    // Reference model: shadow memory plus a per-cycle schedule of expected read returns.
    int          m_starve;
    logic [31:0] smem [256];
    int          sch_own [2][8];
    logic [31:0] sch_dat [2][8];
    int          cyc;
    int          nchk;
    int          nfail;

    task automatic chk(string name, int k, logic [63:0] act, logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s lat%0d cyc=%0d got=%0h expected=%0h", name, lat(k), cyc, act, exp);
        end
    endtask

    function automatic int winner();
        if (rst) return 0;
        if (dma_lock) return dma_req ? 1 : 0;
        if (pram_req && m_starve >= int'(LIM)) return 2;
        if (dma_req) return 1;
        if (pram_req) return 2;
        return 0;
    endfunction

    task automatic model_check();
        int            w;
        int            eo;
        logic          ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [DW-1:0] edat;
        w   = winner();
        ewe = 1'b0; ea = '0; ed = '0;
        if (w == 1) begin ewe = dma_we;  ea = dma_addr;  ed = dma_wdata;  end
        if (w == 2) begin ewe = pram_we; ea = pram_addr; ed = pram_wdata; end
        for (int k = 0; k < 2; k++) begin
            eo   = rst ? 0 : sch_own[k][cyc % 8];
            edat = sch_dat[k][cyc % 8];
            chk("dma_gnt",     k, 64'(dma_gnt_w[k]),  64'(w == 1));
            chk("pram_gnt",    k, 64'(pram_gnt_w[k]), 64'(w == 2));
            chk("ram_we",      k, 64'(ram_we_w[k]),   64'(ewe));
            chk("ram_addr",    k, 64'(ram_ad_w[k]),   64'(ea));
            chk("ram_wdata",   k, 64'(ram_wd_w[k]),   64'(ed));
            chk("dma_rvalid",  k, 64'(dma_rv_w[k]),   64'(eo == 1));
            chk("pram_rvalid", k, 64'(pram_rv_w[k]),  64'(eo == 2));
            chk("dma_rdata",   k, 64'(dma_rd_w[k]),   (eo == 1) ? 64'(edat) : 64'd0);
            chk("pram_rdata",  k, 64'(pram_rd_w[k]),  (eo == 2) ? 64'(edat) : 64'd0);
            chk("starve_cnt",  k, 64'(starve_w[k]),   64'(m_starve));
        end
    endtask

    task automatic model_reset();
        m_starve = 0;
        for (int i = 0; i < 256; i++) smem[i] = pat(i);
        for (int k = 0; k < 2; k++)
            for (int s = 0; s < 8; s++) begin sch_own[k][s] = 0; sch_dat[k][s] = '0; end
    endtask

    task automatic advance();
        int            w;
        logic          ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        w = winner();
        if (rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) sch_own[k][cyc % 8] = 0;
            if (pram_req && w != 2) m_starve = (m_starve >= 15) ? 15 : m_starve + 1;
            else                    m_starve = 0;
            if (w != 0) begin
                ewe = (w == 1) ? dma_we    : pram_we;
                ea  = (w == 1) ? dma_addr  : pram_addr;
                ed  = (w == 1) ? dma_wdata : pram_wdata;
                if (ewe) smem[ea[7:0]] = ed;
                else for (int k = 0; k < 2; k++) begin
                    sch_own[k][(cyc + lat(k)) % 8] = w;
                    sch_dat[k][(cyc + lat(k)) % 8] = smem[ea[7:0]];
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        model_check();
        advance();
    endtask

    task automatic set_in(logic dr, logic dw, logic lk, logic [AW-1:0] da, logic [DW-1:0] dd,
                          logic pr, logic pw, logic [AW-1:0] pa, logic [DW-1:0] pd);
        dma_req = dr; dma_we = dw; dma_lock = lk; dma_addr = da; dma_wdata = dd;
        pram_req = pr; pram_we = pw; pram_addr = pa; pram_wdata = pd;
    endtask

    task automatic idle();
        set_in(0, 0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    typedef struct {
        logic       dreq;
        logic       preq;
        logic       lock;
        logic       egd;
        logic       egp;
        logic [3:0] est;
    } vec_t;

    vec_t tbl [15];

    initial begin
        nchk = 0; nfail = 0; cyc = 0;
        rst = 1'b1;
        idle();
        model_reset();
        @(posedge clk); #1;
        step();
        rst = 1'b0;
        step();

        // DMA read of the preloaded word, latency 1.
        set_in(1, 0, 0, 16'h0010, '0, 0, 0, '0, '0);
        @(negedge clk); model_check();
        chk("t1_dma_gnt", 0, 64'(dma_gnt_w[0]), 64'd1);
        advance();
        idle();
        @(negedge clk); model_check();
        chk("t1_dma_rvalid", 0, 64'(dma_rv_w[0]), 64'd1);
        chk("t1_dma_rdata",  0, 64'(dma_rd_w[0]), 64'hDEADBEEF);
        chk("t1_pram_rdata", 0, 64'(pram_rd_w[0]), 64'd0);
        advance();
        for (int j = 0; j < 3; j++) step();

        // Interleaved reads, latency 3: returns in issue order with own data.
        for (int j = 0; j < 6; j++) begin
            case (j)
                0:       set_in(1, 0, 0, 16'h0001, '0, 0, 0, '0, '0);
                1:       set_in(0, 0, 0, '0, '0, 1, 0, 16'h0002, '0);
                2:       set_in(1, 0, 0, 16'h0003, '0, 0, 0, '0, '0);
                default: idle();
            endcase
            @(negedge clk); model_check();
            if (j == 3) begin
                chk("t4_dma_rvalid", 1, 64'(dma_rv_w[1]), 64'd1);
                chk("t4_dma_rdata",  1, 64'(dma_rd_w[1]), 64'h11111111);
            end
            if (j == 4) begin
                chk("t4_pram_rvalid", 1, 64'(pram_rv_w[1]), 64'd1);
                chk("t4_pram_rdata",  1, 64'(pram_rd_w[1]), 64'h22222222);
            end
            if (j == 5) chk("t4_dma_rdata2", 1, 64'(dma_rd_w[1]), 64'h33333333);
            advance();
        end

        // Pram write then DMA read of the same word.
        for (int j = 0; j < 5; j++) begin
            case (j)
                0:       set_in(0, 0, 0, '0, '0, 1, 1, 16'h0040, 32'h12345678);
                1:       set_in(1, 0, 0, 16'h0040, '0, 0, 0, '0, '0);
                default: idle();
            endcase
            @(negedge clk); model_check();
            if (j == 2) chk("t6_dma_rdata", 0, 64'(dma_rd_w[0]), 64'h12345678);
            if (j == 4) chk("t6_dma_rdata", 1, 64'(dma_rd_w[1]), 64'h12345678);
            advance();
        end
        idle();
        step();

        // Starvation pattern and lock interplay as a vector table.
        for (int i = 0; i < 10; i++)
            tbl[i] = '{1'b1, 1'b1, 1'b0, (i % 5) != 4, (i % 5) == 4, 4'(i % 5)};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0};
        for (int i = 0; i < 15; i++) begin
            set_in(tbl[i].dreq, 0, tbl[i].lock, 16'h0020, '0, tbl[i].preq, 0, 16'h0021, '0);
            @(negedge clk); model_check();
            chk("tbl_dma_gnt",  0, 64'(dma_gnt_w[0]),  64'(tbl[i].egd));
            chk("tbl_pram_gnt", 0, 64'(pram_gnt_w[0]), 64'(tbl[i].egp));
            chk("tbl_starve",   0, 64'(starve_w[0]),   64'(tbl[i].est));
            advance();
        end

        // Lock held with DMA idle: pram starves and the counter saturates.
        for (int i = 0; i < 20; i++) begin
            set_in(0, 0, 1, '0, '0, 1, 1, 16'h0050, 32'h00000077);
            @(negedge clk); model_check();
            chk("lock_pram_gnt", 0, 64'(pram_gnt_w[0]), 64'd0);
            chk("lock_ram_we",   0, 64'(ram_we_w[0]),   64'd0);
            chk("lock_starve",   0, 64'(starve_w[0]),   64'((i > 15) ? 15 : i));
            advance();
        end
        set_in(0, 0, 0, '0, '0, 1, 1, 16'h0050, 32'h00000077);
        @(negedge clk); model_check();
        chk("unlock_pram_gnt", 0, 64'(pram_gnt_w[0]), 64'd1);
        advance();
        idle();
        @(negedge clk); model_check();
        chk("unlock_starve", 0, 64'(starve_w[0]), 64'd0);
        advance();

        // Reset the cycle after a pram read grant: the read never returns.
        for (int j = 0; j < 5; j++) begin
            case (j)
                0:       set_in(0, 0, 0, '0, '0, 1, 0, 16'h0005, '0);
                1:       begin set_in(1, 1, 0, 16'h0006, 32'h1, 1, 1, 16'h0007, 32'h2); rst = 1'b1; end
                default: begin idle(); rst = 1'b0; end
            endcase
            @(negedge clk); model_check();
            if (j == 1) begin
                chk("rst_pram_rvalid", 0, 64'(pram_rv_w[0]), 64'd0);
                chk("rst_pram_rdata",  0, 64'(pram_rd_w[0]), 64'd0);
                chk("rst_dma_gnt",     0, 64'(dma_gnt_w[0]),  64'd0);
                chk("rst_ram_we",      0, 64'(ram_we_w[0]),   64'd0);
            end
            if (j == 2) chk("rst_starve", 0, 64'(starve_w[0]), 64'd0);
            if (j == 3) chk("rst_pram_rvalid", 1, 64'(pram_rv_w[1]), 64'd0);
            advance();
        end

        // Randomised traffic with bursts of lock and occasional reset.
        begin
            logic lk;
            lk = 1'b0;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(15, 0) == 0) lk = ~lk;
                rst = ($urandom_range(299, 0) == 0);
                set_in($urandom_range(9, 0) < 6, 1'($urandom_range(1, 0)), lk,
                       AW'($urandom_range(255, 0)), $urandom(),
                       $urandom_range(9, 0) < 6, 1'($urandom_range(1, 0)),
                       AW'($urandom_range(255, 0)), $urandom());
                step();
            end
            rst = 1'b0;
            idle();
            for (int n = 0; n < 4; n++) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
